// File: rtl/arm_pkg.sv
// Shared ARM-subset decode definitions: field encodings, condition codes,
// the control bundle and the condition/control decode helpers.
package arm_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic       s;
    logic       b;
    logic       mem_read;
    logic       mem_write;
    logic       wb;
    logic [3:0] cmd;
  } ctrl_t;

  // sr is {N, Z, C, V}; the NV encoding never executes.
  function automatic logic cond_pass(input logic [3:0] sr, input logic [3:0] cond);
    logic n, z, c, v, ok;
    {n, z, c, v} = sr;
    case (cond_e'(cond))
      COND_EQ: ok = z;
      COND_NE: ok = !z;
      COND_CS: ok = c;
      COND_CC: ok = !c;
      COND_MI: ok = n;
      COND_PL: ok = !n;
      COND_VS: ok = v;
      COND_VC: ok = !v;
      COND_HI: ok = c && !z;
      COND_LS: ok = !c || z;
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = !z && (n == v);
      COND_LE: ok = z || (n != v);
      COND_AL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Memory ops use the adder for address generation; compares do not write back.
  function automatic ctrl_t decode_ctrl(input logic [1:0] mode, input logic [3:0] op,
                                        input logic sbit);
    ctrl_t c;
    c = '0;
    case (mode)
      MODE_DP: begin
        c.s   = sbit;
        c.cmd = op;
        c.wb  = !(op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
      end
      MODE_MEM: begin
        c.cmd       = OP_ADD;
        c.mem_read  = sbit;
        c.mem_write = !sbit;
        c.wb        = sbit;
      end
      MODE_BR: c.b = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Architectural register file with two read ports and write-first bypass.
module decode_regfile #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 16,
  localparam int unsigned RA = ($clog2(NREG) < 4) ? 4 : $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [RA-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RA-1:0]   raddr1,
  input  logic [RA-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1_c,
  output logic [XLEN-1:0] rdata2_c
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1_c = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
  assign rdata2_c = (we && (waddr == raddr2)) ? wdata : regs[raddr2];

endmodule

// File: rtl/decode_pipe_stage.sv
// ARM-subset decode stage with ID/EX register, handshakes, RAW hazard stall and flush.
// Define DECODE_FWD_EN to forward EX/MEM results instead of stalling (load-use still stalls).
module decode_pipe_stage
  import arm_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 16,
  localparam int unsigned RA = ($clog2(NREG) < 4) ? 4 : $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc_in,
  input  logic [3:0]      sr,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [RA-1:0]   wb_dest,
  input  logic [XLEN-1:0] wb_result,
  input  logic            ex_wb_en,
  input  logic [RA-1:0]   ex_dest,
  input  logic            ex_mem_read,
  input  logic            mem_wb_en,
  input  logic [RA-1:0]   mem_dest,
`ifdef DECODE_FWD_EN
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] mem_result,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic            s,
  output logic            b,
  output logic            mem_read,
  output logic            mem_write,
  output logic            wb_out,
  output logic            imm,
  output logic            two_src,
  output logic [3:0]      cmd,
  output logic [RA-1:0]   src1,
  output logic [RA-1:0]   src2,
  output logic [RA-1:0]   dest,
  output logic [11:0]     shifter_operand,
  output logic [23:0]     signed_immediate,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] val_rn,
  output logic [XLEN-1:0] val_rm
);

  logic [1:0]      mode_c;
  logic            store_c, two_src_c, cond_ok_c;
  logic [RA-1:0]   src1_c, src2_c, dest_c;
  ctrl_t           ctrl_c;
  logic            ex_src1_c, ex_src2_c, mem_src1_c, mem_src2_c, ex_hit_c;
  logic            hazard_c, adv_c, load_c;
  logic [XLEN-1:0] rf_rn_c, rf_rm_c, rn_c, rm_c;

  decode_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_en),
    .waddr    (wb_dest),
    .wdata    (wb_result),
    .raddr1   (src1_c),
    .raddr2   (src2_c),
    .rdata1_c (rf_rn_c),
    .rdata2_c (rf_rm_c)
  );

  // Field extraction, condition gating and RAW hazard detection.
  always_comb begin
    mode_c     = instruction[27:26];
    store_c    = (mode_c == MODE_MEM) && !instruction[20];
    two_src_c  = (!instruction[25] && (mode_c == MODE_DP)) || store_c;
    src1_c     = RA'(instruction[19:16]);
    dest_c     = RA'(instruction[15:12]);
    src2_c     = store_c ? RA'(instruction[15:12]) : RA'(instruction[3:0]);
    cond_ok_c  = cond_pass(sr, instruction[31:28]);
    ctrl_c     = cond_ok_c ? decode_ctrl(mode_c, instruction[24:21], instruction[20]) : '0;
    ex_src1_c  = ex_wb_en && (ex_dest == src1_c);
    ex_src2_c  = ex_wb_en && two_src_c && (ex_dest == src2_c);
    mem_src1_c = mem_wb_en && (mem_dest == src1_c);
    mem_src2_c = mem_wb_en && two_src_c && (mem_dest == src2_c);
    ex_hit_c   = ex_src1_c || ex_src2_c;
`ifdef DECODE_FWD_EN
    hazard_c = in_valid && cond_ok_c && ex_mem_read && ex_hit_c;
    rn_c     = ex_src1_c ? ex_result : (mem_src1_c ? mem_result : rf_rn_c);
    rm_c     = ex_src2_c ? ex_result : (mem_src2_c ? mem_result : rf_rm_c);
`else
    hazard_c = in_valid && cond_ok_c && (ex_hit_c || mem_src1_c || mem_src2_c);
    rn_c     = rf_rn_c;
    rm_c     = rf_rm_c;
`endif
    adv_c  = out_ready || !out_valid;
    load_c = in_valid && adv_c && !hazard_c;
  end

`ifndef DECODE_FWD_EN
  logic unused_ex_mem_read;
  assign unused_ex_mem_read = ex_mem_read;
`endif

  assign in_ready = flush || (adv_c && !hazard_c);

  // ID/EX register: flush drops, hazard bubbles, back-pressure holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid        <= 1'b0;
      s                <= 1'b0;
      b                <= 1'b0;
      mem_read         <= 1'b0;
      mem_write        <= 1'b0;
      wb_out           <= 1'b0;
      imm              <= 1'b0;
      two_src          <= 1'b0;
      cmd              <= '0;
      src1             <= '0;
      src2             <= '0;
      dest             <= '0;
      shifter_operand  <= '0;
      signed_immediate <= '0;
      pc               <= '0;
      val_rn           <= '0;
      val_rm           <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv_c) begin
      out_valid <= load_c;
      if (load_c) begin
        s                <= ctrl_c.s;
        b                <= ctrl_c.b;
        mem_read         <= ctrl_c.mem_read;
        mem_write        <= ctrl_c.mem_write;
        wb_out           <= ctrl_c.wb;
        cmd              <= ctrl_c.cmd;
        imm              <= instruction[25];
        two_src          <= two_src_c;
        src1             <= src1_c;
        src2             <= src2_c;
        dest             <= dest_c;
        shifter_operand  <= instruction[11:0];
        signed_immediate <= instruction[23:0];
        pc               <= pc_in;
        val_rn           <= rn_c;
        val_rm           <= rm_c;
      end
    end
  end

endmodule

// File: doc/decode_pipe_stage.md
# decode_pipe_stage

Parametrised decode stage for the ARM-subset pipeline, generalising the combinational decode block with configurable datapath width and register count. Adds an internal ID/EX output register, valid/ready handshakes on both sides, RAW hazard detection against the EX and MEM stages, and branch flush. It sits between the IF/ID register and the execute stage.

## Interface
- `XLEN`, default 32: datapath width.
- `NREG`, default 16: architectural register count; `RA = $clog2(NREG)`, minimum 4.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1, `in_ready` out 1: upstream handshake.
- `instruction` in 32, `pc_in` in XLEN: fetched word and its PC.
- `sr` in 4: NZCV flags for the condition check.
- `flush` in 1: taken branch resolved in EX.
- `wb_en` in 1, `wb_dest` in RA, `wb_result` in XLEN: register-file write port.
- `ex_wb_en` in 1, `ex_dest` in RA, `ex_mem_read` in 1, `mem_wb_en` in 1, `mem_dest` in RA: hazard sources.
- `ex_result` in XLEN, `mem_result` in XLEN: forwarding data; present only with `DECODE_FWD_EN`.
- `out_valid` out 1, `out_ready` in 1: downstream handshake.
- `s`, `b`, `mem_read`, `mem_write`, `wb_out`, `imm`, `two_src` out 1 each: registered control bits.
- `cmd` out 4: execute command.
- `src1`, `src2`, `dest` out RA each.
- `shifter_operand` out 12, `signed_immediate` out 24, `pc` out XLEN.
- `val_rn`, `val_rm` out XLEN.

## Operation
- Field extraction: src1=instr[19:16], dest=instr[15:12], src2=instr[15:12] if store, else instr[3:0]. The upper bits of src1, src2 and dest are zero when RA>4. imm=instr[25]. two_src=(~imm & instr[27:26]==0) | store.
- Condition fail: the instruction still advances with out_valid=1, but s, b, mem_read, mem_write, wb_out and cmd are all forced to 0.
- Register file: NREG×XLEN, all entries cleared on rst. Write on posedge when wb_en. Reads are write-first: a same-cycle read of wb_dest returns wb_result.
- Hazard, checked only when in_valid: hit if (ex_wb_en & ex_dest==src1) or (mem_wb_en & mem_dest==src1). src2 is also compared when two_src. Hazard checks run only for instructions that pass the condition check.
- On a hazard: in_ready=0 and a bubble is loaded (out_valid←0) if the output register may advance.
- Advance condition: adv = out_ready | ~out_valid. in_ready = adv & ~hazard, or 1 while flush.
- Flush has top priority: out_valid←0, and the current input is accepted and dropped.
- Output register is held when out_valid & ~out_ready.

## Timing
- Latency is 1 cycle: an input accepted at edge N appears on the outputs after edge N.
- Throughput is 1 per cycle with no hazards.
- Reset values: every output 0. in_ready is combinational and equals 1 after reset with no hazard.
- A hold lasts until the downstream accepts. Holding with a pending hazard inserts no extra bubble.
- Simultaneous flush and hazard: the flush wins.
- Simultaneous rst and wb_en: the reset wins and no write occurs.
- rst asserted mid-stall clears the output register and drops the pending instruction.

## Configuration
- `DECODE_FWD_EN` defined: EX and MEM hits are forwarded instead of stalled, with EX taking priority over MEM. val_rn and val_rm take ex_result or mem_result. A stall remains only for load-use (ex_mem_read & EX hit).
- `DECODE_FWD_EN` undefined: every EX or MEM hit stalls, and the ex_result and mem_result ports are absent.

## Structure
- Package `arm_pkg`: opcode constants, condition codes, the control bundle struct (s, b, mem_read, mem_write, wb, cmd), the `cond_pass(sr, cond)` function and the `decode_ctrl` function.
- Sub-module `decode_regfile` (parameters XLEN, NREG; write-first bypass).
- Hazard/forwarding logic and the output register live in the top module.

## Test plan
- Reset, then `ADD R1,R2,R3` (0xE0821003) with out_ready=1 → next cycle out_valid=1, cmd=0100, src1=2, src2=3, dest=1, wb_out=1.
- wb_en writes R2=0x55 while the same cycle decodes a read of R2 → val_rn=0x55.
- ex_wb_en=1, ex_dest=2, instruction reads R2, fwd off → in_ready=0 and a bubble. With fwd on, val_rn=ex_result and no stall.
- ex_mem_read=1, ex_dest=3, instruction reads R3, fwd on → exactly one bubble, then issue once the hazard clears.
- out_ready=0 for 3 cycles → outputs stable and in_ready=0. Release → the next instruction follows on the next cycle.
- EQ-conditioned instruction with sr.Z=0 → out_valid=1 with all control 0. A flush on the same cycle instead gives out_valid=0 and drops the input.
